code_lock: RTL and testbench
============================

# code_lock

Parametrised keypad combination lock, the successor to the fixed 4-button lock FSM. It collects a CODE_LEN-digit code from NUM_BTN one-hot buttons and compares it against a PASSWORD parameter. A wrong-attempt counter forces a timed lockout, and the unlocked state re-locks automatically after a timeout. It sits between the debounced button front end and the lock actuator/status LEDs.

## Interface
Parameters:
- NUM_BTN, 4: number of digit buttons; ≥2.
- CODE_LEN, 4: digits per code; ≥1.
- DIG_W, $clog2(NUM_BTN): bits per digit index (derived).
- PASSWORD, 8'hE4: CODE_LEN*DIG_W bits.
  - First entered digit is in bits [DIG_W-1:0].
  - Default is digit sequence 0,1,2,3.
- MAX_TRIES, 3: wrong verifications allowed before lockout; ≥1.
- LOCKOUT_CYCLES, 16: cycles spent in LOCKOUT; ≥1.
- UNLOCK_CYCLES, 32: cycles in UNLOCKED before auto-relock; 0 disables auto-relock.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- btn  in  NUM_BTN  digit buttons, one-hot; one-cycle pulses from the debouncer.
- enter  in  1  confirm pulse.
- clear  in  1  clear pulse.
- state  out  3  current state encoding.
- locked  out  1  state==LOCKED.
- unlocked  out  1  state==UNLOCKED.
- error  out  1  state==ERROR.
- lockout  out  1  state==LOCKOUT.
- digit_count  out  $clog2(CODE_LEN+1)  digits captured in the current entry.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts.
- invalid  out  1  registered one-cycle pulse: the previous cycle's input was rejected.

## Operation
- An input cycle is invalid, and is ignored entirely, if any of these holds:
  - more than one btn bit is set;
  - enter and any btn are both set;
  - clear and any btn are both set;
  - enter and clear are both set.
- Each invalid cycle raises invalid on the next cycle.
- Invalid detection is active in every state except LOCKOUT.
- Valid digit index = binary encode of the single set btn bit.
- States (3'b encoding):
  - LOCKED (000): enter → INPUT. On this transition, digit_count and the code register clear, and the overflow flag clears. Digits and clear are ignored.
  - INPUT (001): handling of a valid digit:
    - If digit_count<CODE_LEN, write the digit to slot digit_count and increment digit_count.
    - Otherwise set the overflow flag; digit_count saturates.
    - clear → LOCKED; tries_left unchanged.
    - enter → VERIFY.
  - VERIFY (010): lasts exactly one cycle; all inputs ignored. The entry matches iff digit_count==CODE_LEN, overflow is clear, and code==PASSWORD.
    - Match → UNLOCKED; tries_left reloads to MAX_TRIES; timer loads.
    - Mismatch → tries_left decrements. If it becomes 0 → LOCKOUT and the timer loads; else → ERROR.
  - ERROR (011): clear → LOCKED; all other inputs ignored.
  - UNLOCKED (100): clear → LOCKED. If UNLOCK_CYCLES≠0, the timer counts down and expiry → LOCKED.
  - LOCKOUT (101): all inputs ignored, including clear; invalid stays 0. On timer expiry → LOCKED and tries_left reloads to MAX_TRIES.
  - Codes 110/111: → LOCKED on the next cycle.
- Reset values:
  - state = LOCKED (so locked=1; unlocked, error, lockout = 0);
  - digit_count = 0, code register = 0, overflow = 0, timer = 0;
  - tries_left = MAX_TRIES;
  - invalid = 0.
- Reset has priority over every transition, including mid-entry, mid-lockout and mid-unlock.

## Timing
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.
- LOCKED with enter in cycle n: state=INPUT at n+1.
- INPUT with enter in cycle n: VERIFY at n+1; UNLOCKED, ERROR or LOCKOUT at n+2.
- A digit in cycle n: digit_count increments at n+1.
- Timer counts inclusive of the entry cycle:
  - UNLOCKED is held for exactly UNLOCK_CYCLES cycles, then LOCKED.
  - LOCKOUT is held for exactly LOCKOUT_CYCLES cycles.
- Timer: loads N-1 on state entry, decrements each cycle, and expires when it is 0 in the current state.
- clear arriving on the same cycle as UNLOCKED timer expiry → LOCKED; the outcome is identical.
- invalid asserts at n+1 for an offending cycle n.

## Structure
- Package code_lock_pkg holds:
  - state localparams (LOCKED, INPUT, VERIFY, ERROR, UNLOCKED, LOCKOUT) and the 3-bit state width;
  - function onehot_valid (zero or one bit set);
  - function onehot_to_idx.
- Sub-module code_lock_timer: loadable down-counter with inputs load, load_val, en and output done. Its width is $clog2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)+1). It is shared by UNLOCKED and LOCKOUT.
- Top level contains the state register, next-state logic, code shift/slot register, tries counter and invalid pulse.

## Test plan
1. Correct entry with defaults: reset; enter; btn 0001,0010,0100,1000; enter → VERIFY then UNLOCKED two cycles after the second enter; tries_left=3; stays UNLOCKED 32 cycles, then locked=1.
2. Three wrong codes (0,0,0,0), each followed by clear:
   - tries_left goes 2, then 1, and ERROR is reached twice;
   - the third attempt goes to LOCKOUT with lockout=1 for 16 cycles;
   - clear during LOCKOUT is ignored;
   - then LOCKED with tries_left=3.
3. Length errors:
   - A 3-digit correct prefix then enter → ERROR.
   - A 5-digit entry of 0,1,2,3,0 → digit_count stays 4 and the result is ERROR (overflow).
4. Invalid inputs in INPUT:
   - btn=0011 → invalid=1 next cycle, digit_count unchanged;
   - enter+btn, clear+btn, enter+clear → each rejected, state unchanged.
5. Reset mid-operation: assert reset at these points → next cycle state=LOCKED, digit_count=0, tries_left=3, lockout=0:
   - INPUT after 2 digits;
   - mid-LOCKOUT;
   - mid-UNLOCKED.
6. Parameter sweep:
   - NUM_BTN=10, CODE_LEN=6, PASSWORD set for digits 9,8,7,6,5,4 → unlocks.
   - UNLOCK_CYCLES=0 → UNLOCKED persists 1000 cycles until clear.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared definitions for the parametrised keypad combination lock:
// state encoding plus one-hot button decode helpers.
package code_lock_pkg;

  localparam int STATE_W = 3;

  // Widest button bank the decode helpers accept.
  localparam int MAX_BTN = 32;
  localparam int IDX_W   = $clog2(MAX_BTN);

  typedef enum logic [STATE_W-1:0] {
    LOCKED   = 3'b000,
    INPUT    = 3'b001,
    VERIFY   = 3'b010,
    ERROR    = 3'b011,
    UNLOCKED = 3'b100,
    LOCKOUT  = 3'b101
  } state_t;

  function automatic logic onehot_valid(input logic [MAX_BTN-1:0] v);
    return (v & (v - MAX_BTN'(1))) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_BTN-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_BTN; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/code_lock_if.sv
// Keypad-side inputs and status outputs of the combination lock.
// The driver uses master; the lock itself uses slave.
interface code_lock_if #(
  parameter int NUM_BTN   = 4,
  parameter int CODE_LEN  = 4,
  parameter int MAX_TRIES = 3
);

  logic [NUM_BTN-1:0]                 btn;
  logic                               enter;
  logic                               clear;
  logic [code_lock_pkg::STATE_W-1:0]  state;
  logic                               locked;
  logic                               unlocked;
  logic                               error;
  logic                               lockout;
  logic [$clog2(CODE_LEN+1)-1:0]      digit_count;
  logic [$clog2(MAX_TRIES+1)-1:0]     tries_left;
  logic                               invalid;

  modport master (
    output btn, enter, clear,
    input  state, locked, unlocked, error, lockout, digit_count, tries_left, invalid
  );

  modport slave (
    input  btn, enter, clear,
    output state, locked, unlocked, error, lockout, digit_count, tries_left, invalid
  );

endinterface

// File: rtl/code_lock_timer.sv
// Loadable down-counter shared by the UNLOCKED auto-relock and the LOCKOUT hold.
// done is high whenever the count sits at zero.
module code_lock_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load wins over counting so a state entry always restarts the interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/code_lock.sv
// Keypad combination lock: collects CODE_LEN digits, checks them against PASSWORD,
// counts wrong attempts into a timed lockout and auto-relocks after unlocking.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int                          NUM_BTN        = 4,
  parameter int                          CODE_LEN       = 4,
  parameter int                          DIG_W          = $clog2(NUM_BTN),
  parameter logic [CODE_LEN*DIG_W-1:0]   PASSWORD       = 8'hE4,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 16,
  parameter int                          UNLOCK_CYCLES  = 32
) (
  input logic          clk,
  input logic          reset,
  code_lock_if.slave   bus
);

  localparam int CNT_W   = $clog2(CODE_LEN+1);
  localparam int TRY_W   = $clog2(MAX_TRIES+1);
  localparam int TMAX    = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TIMER_W = $clog2(TMAX+1);

  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  =
    (UNLOCK_CYCLES == 0) ? '0 : TIMER_W'(UNLOCK_CYCLES - 1);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            digit_count_q, digit_count_d;
  logic [CODE_LEN*DIG_W-1:0]   code_q, code_d;
  logic                        overflow_q, overflow_d;
  logic [TRY_W-1:0]            tries_q, tries_d;
  logic                        invalid_q, invalid_d;

  logic                        btn_any;
  logic                        in_bad;
  logic [DIG_W-1:0]            digit;
  logic                        match;
  logic                        timer_load;
  logic [TIMER_W-1:0]          timer_val;
  logic                        timer_en;
  logic                        timer_done;

  // A rejected cycle is dropped completely; only the invalid pulse reflects it.
  assign btn_any = |bus.btn;
  assign in_bad  = !onehot_valid(MAX_BTN'(bus.btn))
                   || (bus.enter && btn_any)
                   || (bus.clear && btn_any)
                   || (bus.enter && bus.clear);
  assign digit   = DIG_W'(onehot_to_idx(MAX_BTN'(bus.btn)));

  assign match = (digit_count_q == CNT_W'(CODE_LEN)) && !overflow_q && (code_q == PASSWORD);

  assign timer_en = (state_q == UNLOCKED) || (state_q == LOCKOUT);

  code_lock_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LOCKED;
      digit_count_q <= '0;
      code_q        <= '0;
      overflow_q    <= 1'b0;
      tries_q       <= TRY_W'(MAX_TRIES);
      invalid_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_count_q <= digit_count_d;
      code_q        <= code_d;
      overflow_q    <= overflow_d;
      tries_q       <= tries_d;
      invalid_q     <= invalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    digit_count_d = digit_count_q;
    code_d        = code_q;
    overflow_d    = overflow_q;
    tries_d       = tries_q;
    invalid_d     = in_bad && (state_q != LOCKOUT);
    timer_load    = 1'b0;
    timer_val     = '0;

    case (state_q)
      LOCKED: begin
        if (!in_bad && bus.enter) begin
          state_d       = INPUT;
          digit_count_d = '0;
          code_d        = '0;
          overflow_d    = 1'b0;
        end
      end

      INPUT: begin
        if (!in_bad) begin
          if (btn_any) begin
            if (digit_count_q < CNT_W'(CODE_LEN)) begin
              for (int i = 0; i < CODE_LEN; i++) begin
                if (digit_count_q == CNT_W'(i)) code_d[i*DIG_W +: DIG_W] = digit;
              end
              digit_count_d = digit_count_q + CNT_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else if (bus.clear) begin
            state_d = LOCKED;
          end else if (bus.enter) begin
            state_d = VERIFY;
          end
        end
      end

      VERIFY: begin
        if (match) begin
          state_d    = UNLOCKED;
          tries_d    = TRY_W'(MAX_TRIES);
          timer_load = 1'b1;
          timer_val  = UNLOCK_LOAD;
        end else if (tries_q <= TRY_W'(1)) begin
          state_d    = LOCKOUT;
          tries_d    = '0;
          timer_load = 1'b1;
          timer_val  = LOCKOUT_LOAD;
        end else begin
          state_d = ERROR;
          tries_d = tries_q - TRY_W'(1);
        end
      end

      ERROR: begin
        if (!in_bad && bus.clear) state_d = LOCKED;
      end

      UNLOCKED: begin
        if ((!in_bad && bus.clear) || ((UNLOCK_CYCLES != 0) && timer_done)) begin
          state_d = LOCKED;
        end
      end

      LOCKOUT: begin
        if (timer_done) begin
          state_d = LOCKED;
          tries_d = TRY_W'(MAX_TRIES);
        end
      end

      default: state_d = LOCKED;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.unlocked    = (state_q == UNLOCKED);
  assign bus.error       = (state_q == ERROR);
  assign bus.lockout     = (state_q == LOCKOUT);
  assign bus.digit_count = digit_count_q;
  assign bus.tries_left  = tries_q;
  assign bus.invalid     = invalid_q;

endmodule

// File: tb/tb_code_lock.sv
// Scoreboard bench for code_lock: directed and random keypad traffic against a
// queue-of-digits reference model, plus parameter-sweep instances.
module tb_code_lock;

  localparam int NB = 4;
  localparam int CL = 4;
  localparam int MT = 3;
  localparam int LC = 16;
  localparam int UC = 32;

  localparam int S_LOCKED   = 0;
  localparam int S_INPUT    = 1;
  localparam int S_VERIFY   = 2;
  localparam int S_ERROR    = 3;
  localparam int S_UNLOCKED = 4;
  localparam int S_LOCKOUT  = 5;

  typedef struct {
    int st;
    int cnt;
    int tries;
    int inv;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  code_lock_if #(.NUM_BTN(NB), .CODE_LEN(CL), .MAX_TRIES(MT)) bus_a ();
  code_lock_if #(.NUM_BTN(10), .CODE_LEN(6),  .MAX_TRIES(3))  bus_b ();
  code_lock_if #(.NUM_BTN(4),  .CODE_LEN(4),  .MAX_TRIES(3))  bus_c ();

  code_lock #(
    .NUM_BTN(NB), .CODE_LEN(CL), .PASSWORD(8'hE4), .MAX_TRIES(MT),
    .LOCKOUT_CYCLES(LC), .UNLOCK_CYCLES(UC)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  code_lock #(
    .NUM_BTN(10), .CODE_LEN(6), .PASSWORD(24'h456789)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  code_lock #(
    .UNLOCK_CYCLES(0)
  ) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  int   m_state;
  int   m_digits[$];
  int   m_tries;
  int   m_elapsed;
  int   m_inv;
  int   pw_digits[CL] = '{0, 1, 2, 3};

  task automatic checkOutput(input string name, input int got, input int want);
    checks_total++;
    if (got == want) checks_passed++;
    else $display("[TB] FAIL %s at %0t: got %0d, required %0d", name, $time, got, want);
  endtask

  // Reference model: the entry is a plain list of digits and each timed state
  // counts how many cycles it has already been occupied.
  task automatic model_step(input logic [NB-1:0] b, input bit e, input bit c, input bit r);
    int  ones;
    int  idx;
    bit  bad;
    bit  hit;
    ones = $countones(b);
    idx  = 0;
    for (int i = 0; i < NB; i++) if (b[i]) idx = i;
    bad = (ones > 1) || (e && ones > 0) || (c && ones > 0) || (e && c);
    if (r) begin
      m_state = S_LOCKED;
      m_digits.delete();
      m_tries   = MT;
      m_elapsed = 0;
      m_inv     = 0;
      return;
    end
    m_inv = (bad && m_state != S_LOCKOUT) ? 1 : 0;
    case (m_state)
      S_LOCKED: if (!bad && e) begin
        m_state = S_INPUT;
        m_digits.delete();
      end
      S_INPUT: if (!bad) begin
        if (ones == 1) m_digits.push_back(idx);
        else if (c) m_state = S_LOCKED;
        else if (e) m_state = S_VERIFY;
      end
      S_VERIFY: begin
        hit = (m_digits.size() == CL);
        if (hit) for (int i = 0; i < CL; i++) if (m_digits[i] != pw_digits[i]) hit = 1'b0;
        if (hit) begin
          m_state   = S_UNLOCKED;
          m_tries   = MT;
          m_elapsed = 0;
        end else begin
          m_tries--;
          m_elapsed = 0;
          m_state   = (m_tries == 0) ? S_LOCKOUT : S_ERROR;
        end
      end
      S_ERROR: if (!bad && c) m_state = S_LOCKED;
      S_UNLOCKED: begin
        if (!bad && c) m_state = S_LOCKED;
        else if (UC != 0 && m_elapsed == UC - 1) m_state = S_LOCKED;
        else m_elapsed++;
      end
      S_LOCKOUT: begin
        if (m_elapsed == LC - 1) begin
          m_state = S_LOCKED;
          m_tries = MT;
        end else m_elapsed++;
      end
      default: m_state = S_LOCKED;
    endcase
  endtask

  task automatic applyStimulus(input logic [NB-1:0] b, input bit e, input bit c, input bit r);
    exp_t x;
    @(negedge clk);
    bus_a.btn   = b;
    bus_a.enter = e;
    bus_a.clear = c;
    reset       = r;
    model_step(b, e, c, r);
    x.st    = m_state;
    x.cnt   = (m_digits.size() > CL) ? CL : m_digits.size();
    x.tries = m_tries;
    x.inv   = m_inv;
    exp_q.push_back(x);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_code(input int digs[8], input int n);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(NB'(1 << digs[i]), 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drive_b(input logic [9:0] b, input bit e, input bit c);
    @(negedge clk);
    bus_b.btn = b; bus_b.enter = e; bus_b.clear = c;
    @(posedge clk);
    #1;
    bus_b.btn = '0; bus_b.enter = 1'b0; bus_b.clear = 1'b0;
  endtask

  task automatic drive_c(input logic [3:0] b, input bit e, input bit c);
    @(negedge clk);
    bus_c.btn = b; bus_c.enter = e; bus_c.clear = c;
    @(posedge clk);
    #1;
    bus_c.btn = '0; bus_c.enter = 1'b0; bus_c.clear = 1'b0;
  endtask

  // Monitor: every cycle the lock presents a fresh registered status word.
  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checkOutput("state", int'(bus_a.state), x.st);
      checkOutput("digit_count", int'(bus_a.digit_count), x.cnt);
      checkOutput("tries_left", int'(bus_a.tries_left), x.tries);
      checkOutput("invalid", int'(bus_a.invalid), x.inv);
      checkOutput("status_flags",
                  int'({bus_a.locked, bus_a.unlocked, bus_a.error, bus_a.lockout}),
                  int'({x.st == S_LOCKED, x.st == S_UNLOCKED, x.st == S_ERROR, x.st == S_LOCKOUT}));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          k;
    logic [NB-1:0] rb;
    bus_a.btn = '0; bus_a.enter = 1'b0; bus_a.clear = 1'b0;
    bus_b.btn = '0; bus_b.enter = 1'b0; bus_b.clear = 1'b0;
    bus_c.btn = '0; bus_c.enter = 1'b0; bus_c.clear = 1'b0;
    $display("[TB] starting code_lock bench");

    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    idle(2);

    enter_code('{0, 1, 2, 3, 0, 0, 0, 0}, 4);
    idle(40);

    for (int a = 0; a < 3; a++) begin
      enter_code('{0, 0, 0, 0, 0, 0, 0, 0}, 4);
      idle(2);
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
    end
    idle(20);

    enter_code('{0, 1, 2, 0, 0, 0, 0, 0}, 3);
    idle(2);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    enter_code('{0, 1, 2, 3, 0, 0, 0, 0}, 5);
    idle(2);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);

    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);

    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    for (int a = 0; a < 3; a++) begin
      enter_code('{1, 1, 1, 1, 0, 0, 0, 0}, 4);
      idle(2);
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
    end
    idle(5);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    enter_code('{0, 1, 2, 3, 0, 0, 0, 0}, 4);
    idle(10);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);

    enter_code('{0, 1, 2, 3, 0, 0, 0, 0}, 4);
    idle(32);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    idle(2);

    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 40);
      if (k < 4) begin
        enter_code('{0, 1, 2, 3, 0, 0, 0, 0}, 4);
      end else if (k < 14) begin
        idle(1);
      end else if (k < 24) begin
        applyStimulus(NB'(1 << $urandom_range(0, NB - 1)), 1'b0, 1'b0, 1'b0);
      end else if (k < 29) begin
        applyStimulus('0, 1'b1, 1'b0, 1'b0);
      end else if (k < 33) begin
        applyStimulus('0, 1'b0, 1'b1, 1'b0);
      end else if (k < 40) begin
        rb = NB'($urandom_range(0, 15));
        applyStimulus(rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
      end
    end
    idle(1);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drain", exp_q.size(), 0);

    drive_b(10'd0, 1'b1, 1'b0);
    checkOutput("sweep10_state_input", int'(bus_b.state), S_INPUT);
    for (int d = 9; d >= 4; d--) drive_b(10'(1 << d), 1'b0, 1'b0);
    checkOutput("sweep10_digit_count", int'(bus_b.digit_count), 6);
    drive_b(10'd0, 1'b1, 1'b0);
    checkOutput("sweep10_state_verify", int'(bus_b.state), S_VERIFY);
    drive_b(10'd0, 1'b0, 1'b0);
    checkOutput("sweep10_unlocked", int'(bus_b.unlocked), 1);
    checkOutput("sweep10_tries_left", int'(bus_b.tries_left), 3);

    drive_c(4'd0, 1'b1, 1'b0);
    for (int d = 0; d < 4; d++) drive_c(4'(1 << d), 1'b0, 1'b0);
    drive_c(4'd0, 1'b1, 1'b0);
    drive_c(4'd0, 1'b0, 1'b0);
    checkOutput("norelock_unlocked_entry", int'(bus_c.unlocked), 1);
    repeat (1000) drive_c(4'd0, 1'b0, 1'b0);
    checkOutput("norelock_unlocked_after_1000", int'(bus_c.state), S_UNLOCKED);
    drive_c(4'd0, 1'b0, 1'b1);
    checkOutput("norelock_clear_locks", int'(bus_c.locked), 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
